mem_fill_ctrl: RTL

MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

---
 rtl/mem_fill_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_fill_ctrl.sv
// Cache miss fill / write-through controller: streams an 8-word block from memory
// into the cache data array, or issues a single write-through cycle to memory.
module mem_fill_ctrl #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_req,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   input  logic                  wt_req,
   input  logic [ADDR_WIDTH-1:0] wt_addr,
   input  logic [15:0]           wt_data,
   output logic                  busy,
   output logic                  fill_we,
   output logic [2:0]            fill_word_idx,
   output logic [15:0]           fill_data,
   output logic                  fill_done,
   output logic                  wt_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_enable,
   output logic                  mem_wr,
   output logic [15:0]           mem_data_in,
   input  logic [15:0]           mem_data_out,
   output logic [1:0]            o_dbg_state
);

   // Requests are levels held by the requester until the matching done pulse
   // (valid = *_req, ready = IDLE state); they are only sampled while IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                r_state;
   logic [2:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_wt_addr;
   logic [15:0]           r_wt_data;

   logic                  w_fill;
   logic                  w_write;
   logic [ADDR_WIDTH-1:0] w_fill_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 3'd0;
         r_base    <= '0;
         r_wt_addr <= '0;
         r_wt_data <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (miss_req) begin
                  r_base  <= {miss_addr[ADDR_WIDTH-1:4], 4'b0000};
                  r_cnt   <= 3'd0;
                  r_state <= S_FILL;
               end else if (wt_req) begin
                  r_wt_addr <= {wt_addr[ADDR_WIDTH-1:1], 1'b0};
                  r_wt_data <= wt_data;
                  r_state   <= S_WRITE;
               end
            end
            S_FILL: begin
               // Counter wraps back to 0 on the last word, ready for the next fill.
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_state <= S_IDLE;
               end
            end
            S_WRITE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_fill  = (r_state == S_FILL);
   assign w_write = (r_state == S_WRITE);
   // Base has its low 4 bits clear, so OR-ing the word offset never carries.
   assign w_fill_addr = r_base | {{(ADDR_WIDTH-4){1'b0}}, r_cnt, 1'b0};

   always_comb begin
      busy          = (r_state != S_IDLE);
      fill_we       = w_fill;
      fill_word_idx = w_fill ? r_cnt : 3'd0;
      fill_data     = w_fill ? mem_data_out : 16'd0;
      fill_done     = w_fill && (r_cnt == 3'd7);
      wt_done       = w_write;
      mem_enable    = w_fill || w_write;
      mem_wr        = w_write;
      mem_data_in   = w_write ? r_wt_data : 16'd0;
      mem_addr      = '0;
      if (w_fill) begin
         mem_addr = w_fill_addr;
      end else if (w_write) begin
         mem_addr = r_wt_addr;
      end
   end

   assign o_dbg_state = r_state;

endmodule
